// File: rtl/encoder_value_tracker.sv
// Turns the decoder's wrapping 8-bit click count into signed deltas and applies
// them one step per clock to a bounded user value, with saturate or wrap handling.
module encoder_value_tracker #(
   parameter int unsigned VALUE_W     = 8,
   parameter int unsigned MIN_VAL     = 0,
   parameter int unsigned MAX_VAL     = 100,
   parameter int unsigned INIT_VAL    = 50,
   parameter int unsigned WRAP        = 0,
   parameter int unsigned STEP        = 1,
   parameter int unsigned COARSE_STEP = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         count,
   input  logic               coarse,
   input  logic               load,
   input  logic [VALUE_W-1:0] load_value,
   output logic [VALUE_W-1:0] value,
   output logic               at_min,
   output logic               at_max,
   output logic               up_pulse,
   output logic               down_pulse,
   output logic               busy
);

   localparam int unsigned AW = VALUE_W + 2;
   localparam int unsigned PW = 10;

   localparam logic [AW-1:0]      MIN_A   = AW'(MIN_VAL);
   localparam logic [AW-1:0]      MAX_A   = AW'(MAX_VAL);
   localparam logic [AW-1:0]      RANGE_A = AW'(MAX_VAL - MIN_VAL + 1);
   localparam logic [AW-1:0]      STEP_A  = AW'(STEP);
   localparam logic [AW-1:0]      CSTEP_A = AW'(COARSE_STEP);
   localparam logic [VALUE_W-1:0] MIN_V   = VALUE_W'(MIN_VAL);
   localparam logic [VALUE_W-1:0] MAX_V   = VALUE_W'(MAX_VAL);
   localparam logic [VALUE_W-1:0] INIT_V  = VALUE_W'(INIT_VAL);
   localparam bit                 WRAP_EN     = (WRAP != 0);
   localparam bit                 INIT_AT_MIN = (INIT_VAL == MIN_VAL);
   localparam bit                 INIT_AT_MAX = (INIT_VAL == MAX_VAL);

   logic [VALUE_W-1:0] r_value;
   logic               r_at_min;
   logic               r_at_max;
   logic               r_up;
   logic               r_down;
   logic               r_busy;
   logic [7:0]         r_prev;
   logic               r_primed;
   logic [PW-1:0]      r_pending;

   logic [7:0]         w_delta;
   logic [PW:0]        w_sign;
   logic [PW:0]        w_pend_sum;
   logic [PW-1:0]      w_pend_clamped;
   logic [AW-1:0]      w_step_s;
   logic [AW-1:0]      w_val_ext;
   logic [AW-1:0]      w_sum;
   logic [AW-1:0]      w_step_val;
   logic [AW-1:0]      w_load_ext;
   logic [AW-1:0]      w_load_val;
   logic               w_step_en;
   logic               w_changed;
   logic [VALUE_W-1:0] w_value_d;
   logic [PW-1:0]      w_pend_d;
   logic               w_up_d;
   logic               w_down_d;

   assign value      = r_value;
   assign at_min     = r_at_min;
   assign at_max     = r_at_max;
   assign up_pulse   = r_up;
   assign down_pulse = r_down;
   assign busy       = r_busy;

   // Pending accumulator: drain one click toward zero, add the new delta, clamp to 10-bit signed.
   assign w_delta    = r_primed ? (count - r_prev) : 8'h00;
   assign w_sign     = r_pending[PW-1] ? {(PW+1){1'b1}}
                     : ((r_pending != '0) ? (PW+1)'(1) : '0);
   assign w_pend_sum = {r_pending[PW-1], r_pending} - w_sign
                     + {{(PW-7){w_delta[7]}}, w_delta};

   always_comb begin
      w_pend_clamped = w_pend_sum[PW-1:0];
      if (!w_pend_sum[PW] && w_pend_sum[PW-1])
         w_pend_clamped = {1'b0, {(PW-1){1'b1}}};
      else if (w_pend_sum[PW] && !w_pend_sum[PW-1])
         w_pend_clamped = {1'b1, {(PW-1){1'b0}}};
   end

   // One step of the tracked value, all unsigned in VALUE_W+2 bits so nothing overflows.
   assign w_step_en = (r_pending != '0);
   assign w_step_s  = coarse ? CSTEP_A : STEP_A;
   assign w_val_ext = {2'b00, r_value};
   assign w_sum     = w_val_ext + w_step_s;

   always_comb begin
      w_step_val = w_val_ext;
      if (!r_pending[PW-1]) begin
         if (w_sum > MAX_A)
            w_step_val = WRAP_EN ? (w_sum - RANGE_A) : MAX_A;
         else
            w_step_val = w_sum;
      end else begin
         if (w_val_ext < (MIN_A + w_step_s))
            w_step_val = WRAP_EN ? (w_val_ext + RANGE_A - w_step_s) : MIN_A;
         else
            w_step_val = w_val_ext - w_step_s;
      end
   end

   assign w_load_ext = {2'b00, load_value};
   assign w_load_val = (w_load_ext < MIN_A) ? MIN_A
                     : ((w_load_ext > MAX_A) ? MAX_A : w_load_ext);
   assign w_changed  = (VALUE_W'(w_step_val) != r_value);

   // Load wins over stepping and discards both the backlog and this edge's delta.
   always_comb begin
      w_value_d = r_value;
      w_pend_d  = w_pend_clamped;
      w_up_d    = 1'b0;
      w_down_d  = 1'b0;
      if (load) begin
         w_value_d = VALUE_W'(w_load_val);
         w_pend_d  = '0;
      end else if (w_step_en) begin
         w_value_d = VALUE_W'(w_step_val);
         w_up_d    = !r_pending[PW-1] && (WRAP_EN || w_changed);
         w_down_d  =  r_pending[PW-1] && (WRAP_EN || w_changed);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_value   <= INIT_V;
         r_at_min  <= INIT_AT_MIN;
         r_at_max  <= INIT_AT_MAX;
         r_up      <= 1'b0;
         r_down    <= 1'b0;
         r_busy    <= 1'b0;
         r_prev    <= 8'h00;
         r_primed  <= 1'b0;
         r_pending <= '0;
      end else begin
         r_value   <= w_value_d;
         r_at_min  <= (w_value_d == MIN_V);
         r_at_max  <= (w_value_d == MAX_V);
         r_up      <= w_up_d;
         r_down    <= w_down_d;
         r_busy    <= (w_pend_d != '0);
         r_prev    <= count;
         r_primed  <= 1'b1;
         r_pending <= w_pend_d;
      end
   end

endmodule

// File: tb/tb_encoder_value_tracker.sv
// Directed bench: a saturating default instance and a small wrap-mode instance,
// driven from per-cycle vector tables plus a few multi-cycle sequences.
module tb_encoder_value_tracker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [7:0] cnt_a, cnt_b, lv_a, lv_b;
   logic       crs_a, crs_b, ld_a, ld_b;
   logic [7:0] val_a, val_b;
   logic       amin_a, amax_a, up_a, dn_a, bsy_a;
   logic       amin_b, amax_b, up_b, dn_b, bsy_b;

   encoder_value_tracker u_sat (
      .clk(clk), .reset(reset), .count(cnt_a), .coarse(crs_a), .load(ld_a),
      .load_value(lv_a), .value(val_a), .at_min(amin_a), .at_max(amax_a),
      .up_pulse(up_a), .down_pulse(dn_a), .busy(bsy_a));

   encoder_value_tracker #(
      .MIN_VAL(0), .MAX_VAL(9), .INIT_VAL(5), .WRAP(1), .STEP(1), .COARSE_STEP(4)
   ) u_wrap (
      .clk(clk), .reset(reset), .count(cnt_b), .coarse(crs_b), .load(ld_b),
      .load_value(lv_b), .value(val_b), .at_min(amin_b), .at_max(amax_b),
      .up_pulse(up_b), .down_pulse(dn_b), .busy(bsy_b));

   typedef struct {
      int ld; int lv; int cnt; int crs;
      int val; int up; int dn; int bsy; int amin; int amax;
   } vec_t;

   vec_t ta[$];
   vec_t tw[$];
   int   total = 0;
   int   bad   = 0;

   function automatic vec_t mk(int ld, int lv, int cnt, int crs, int val,
                               int up, int dn, int bsy, int amin, int amax);
      vec_t v;
      v.ld = ld; v.lv = lv; v.cnt = cnt; v.crs = crs; v.val = val;
      v.up = up; v.dn = dn; v.bsy = bsy; v.amin = amin; v.amax = amax;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %0d want %0d", name, idx, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input vec_t v);
      if (!sel) begin
         ld_a = (v.ld != 0); lv_a = 8'(v.lv); cnt_a = 8'(v.cnt); crs_a = (v.crs != 0);
      end else begin
         ld_b = (v.ld != 0); lv_b = 8'(v.lv); cnt_b = 8'(v.cnt); crs_b = (v.crs != 0);
      end
   endtask

   task automatic check_outs(input bit sel, input string tag, input int idx, input vec_t v);
      check({tag, ".value"},  idx, sel ? int'(val_b)  : int'(val_a),  v.val);
      check({tag, ".up"},     idx, sel ? int'(up_b)   : int'(up_a),   v.up);
      check({tag, ".down"},   idx, sel ? int'(dn_b)   : int'(dn_a),   v.dn);
      check({tag, ".busy"},   idx, sel ? int'(bsy_b)  : int'(bsy_a),  v.bsy);
      check({tag, ".at_min"}, idx, sel ? int'(amin_b) : int'(amin_a), v.amin);
      check({tag, ".at_max"}, idx, sel ? int'(amax_b) : int'(amax_a), v.amax);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      int n;

      // Saturating instance, one row per clock edge.
      for (int i = 0; i < 10; i++) ta.push_back(mk(0, 0, 'h37, 0, 50, 0, 0, 0, 0, 0));
      ta.push_back(mk(1, 50, 'h00, 0, 50, 0, 0, 0, 0, 0));
      ta.push_back(mk(0, 0, 'h01, 0, 50, 0, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h01, 0, 51, 1, 0, 0, 0, 0));
      ta.push_back(mk(0, 0, 'h01, 0, 51, 0, 0, 0, 0, 0));
      ta.push_back(mk(1, 50, 'hFE, 0, 50, 0, 0, 0, 0, 0));
      ta.push_back(mk(0, 0, 'h02, 0, 50, 0, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h02, 0, 51, 1, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h02, 0, 52, 1, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h02, 0, 53, 1, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h02, 0, 54, 1, 0, 0, 0, 0));
      ta.push_back(mk(0, 0, 'h02, 0, 54, 0, 0, 0, 0, 0));
      ta.push_back(mk(0, 0, 'h06, 1, 54, 0, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h06, 1, 64, 1, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h06, 1, 74, 1, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h06, 1, 84, 1, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h06, 1, 94, 1, 0, 0, 0, 0));
      ta.push_back(mk(0, 0, 'h06, 1, 94, 0, 0, 0, 0, 0));
      ta.push_back(mk(1, 98, 'h06, 0, 98, 0, 0, 0, 0, 0));
      ta.push_back(mk(0, 0, 'h0B, 0, 98, 0, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h0B, 0, 99, 1, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h0B, 0, 100, 1, 0, 1, 0, 1));
      ta.push_back(mk(0, 0, 'h0B, 0, 100, 0, 0, 1, 0, 1));
      ta.push_back(mk(0, 0, 'h0B, 0, 100, 0, 0, 1, 0, 1));
      ta.push_back(mk(0, 0, 'h0B, 0, 100, 0, 0, 0, 0, 1));
      ta.push_back(mk(0, 0, 'h0B, 0, 100, 0, 0, 0, 0, 1));
      ta.push_back(mk(1, 2, 'h0B, 0, 2, 0, 0, 0, 0, 0));
      ta.push_back(mk(0, 0, 'h06, 0, 2, 0, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h06, 0, 1, 0, 1, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h06, 0, 0, 0, 1, 1, 1, 0));
      ta.push_back(mk(0, 0, 'h06, 0, 0, 0, 0, 1, 1, 0));
      ta.push_back(mk(0, 0, 'h06, 0, 0, 0, 0, 1, 1, 0));
      ta.push_back(mk(0, 0, 'h06, 0, 0, 0, 0, 0, 1, 0));
      ta.push_back(mk(1, 50, 'h06, 0, 50, 0, 0, 0, 0, 0));
      ta.push_back(mk(0, 0, 'h1A, 0, 50, 0, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h1A, 0, 51, 1, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h1A, 0, 52, 1, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'h1A, 0, 53, 1, 0, 1, 0, 0));
      ta.push_back(mk(1, 200, 'h1A, 0, 100, 0, 0, 0, 0, 1));
      ta.push_back(mk(0, 0, 'h1A, 0, 100, 0, 0, 0, 0, 1));
      ta.push_back(mk(0, 0, 'h1A, 0, 100, 0, 0, 0, 0, 1));
      ta.push_back(mk(1, 50, 'h01, 0, 50, 0, 0, 0, 0, 0));
      ta.push_back(mk(0, 0, 'hFF, 0, 50, 0, 0, 1, 0, 0));
      ta.push_back(mk(0, 0, 'hFF, 0, 49, 0, 1, 1, 0, 0));
      ta.push_back(mk(0, 0, 'hFF, 0, 48, 0, 1, 0, 0, 0));
      ta.push_back(mk(0, 0, 'hFF, 0, 48, 0, 0, 0, 0, 0));

      // Wrap instance: range 0..9, fine 1, coarse 4.
      tw.push_back(mk(0, 0, 'h00, 0, 5, 0, 0, 0, 0, 0));
      tw.push_back(mk(1, 9, 'h00, 0, 9, 0, 0, 0, 0, 1));
      tw.push_back(mk(0, 0, 'h01, 0, 9, 0, 0, 1, 0, 1));
      tw.push_back(mk(0, 0, 'h01, 0, 0, 1, 0, 0, 1, 0));
      tw.push_back(mk(0, 0, 'h00, 0, 0, 0, 0, 1, 1, 0));
      tw.push_back(mk(0, 0, 'h00, 0, 9, 0, 1, 0, 0, 1));
      tw.push_back(mk(1, 7, 'h00, 0, 7, 0, 0, 0, 0, 0));
      tw.push_back(mk(0, 0, 'h01, 1, 7, 0, 0, 1, 0, 0));
      tw.push_back(mk(0, 0, 'h01, 1, 1, 1, 0, 0, 0, 0));
      tw.push_back(mk(0, 0, 'h01, 1, 1, 0, 0, 0, 0, 0));
      tw.push_back(mk(0, 0, 'h00, 1, 1, 0, 0, 1, 0, 0));
      tw.push_back(mk(0, 0, 'h00, 1, 7, 0, 1, 0, 0, 0));

      reset = 1'b1;
      cnt_a = 8'h37; crs_a = 1'b0; ld_a = 1'b0; lv_a = 8'h00;
      cnt_b = 8'h00; crs_b = 1'b0; ld_b = 1'b0; lv_b = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_outs(1'b0, "reset_sat", 0, mk(0, 0, 0, 0, 50, 0, 0, 0, 0, 0));
      check_outs(1'b1, "reset_wrap", 0, mk(0, 0, 0, 0, 5, 0, 0, 0, 0, 0));
      reset = 1'b0;

      foreach (ta[i]) begin
         drive(1'b0, ta[i]);
         step();
         check_outs(1'b0, "sat", i, ta[i]);
      end

      foreach (tw[i]) begin
         drive(1'b1, tw[i]);
         step();
         check_outs(1'b1, "wrap", i, tw[i]);
      end

      // Five +127 jumps overflow the backlog; it must clamp at +511.
      ld_a = 1'b1; lv_a = 8'd50; cnt_a = 8'h00; crs_a = 1'b0;
      step();
      ld_a = 1'b0;
      cnt_a = 8'h7F; step();
      cnt_a = 8'hFE; step();
      cnt_a = 8'h7D; step();
      cnt_a = 8'hFC; step();
      cnt_a = 8'h7B; step();
      n = 0;
      while (bsy_a && n < 1000) begin
         n++;
         step();
      end
      check("pend_clamp.busy_cycles", 0, n, 511);
      check("pend_clamp.value", 0, int'(val_a), 100);
      check("pend_clamp.at_max", 0, int'(amax_a), 1);

      // Asynchronous reset in the middle of a burst.
      ld_a = 1'b1; lv_a = 8'd50; cnt_a = 8'h10;
      step();
      ld_a = 1'b0; cnt_a = 8'h24;
      repeat (4) step();
      check("burst.value", 0, int'(val_a), 53);
      check("burst.busy", 0, int'(bsy_a), 1);
      reset = 1'b1;
      #1;
      check("async_rst.value", 0, int'(val_a), 50);
      check("async_rst.busy", 0, int'(bsy_a), 0);
      check("async_rst.up", 0, int'(up_a), 0);
      cnt_a = 8'h60;
      repeat (2) step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check_outs(1'b0, "post_rst", i, mk(0, 0, 0, 0, 50, 0, 0, 0, 0, 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/encoder_value_tracker.md
Name: encoder_value_tracker

Overview:
- Downstream consumer of the quadrature decoder's 8-bit click count.
- Tracks frame-to-frame movement of the free-running, wrapping count and converts it into signed click deltas.
- Applies those deltas, one step per clock, to a bounded user value (menu index, setpoint, volume).
- Provides saturating or wrap-around range handling, fine/coarse step, synchronous preset, and per-step direction pulses for UI logic.

Parameters:
VALUE_W, 8, width of value and load_value (unsigned)
MIN_VAL, 0, lower bound of value
MAX_VAL, 100, upper bound of value (MIN_VAL < MAX_VAL < 2**VALUE_W)
INIT_VAL, 50, value after reset (MIN_VAL..MAX_VAL)
WRAP, 0, 0 = saturate at bounds, 1 = wrap modulo range
STEP, 1, fine step size per click (1 <= STEP <= MAX_VAL-MIN_VAL+1)
COARSE_STEP, 10, coarse step size per click (same constraint as STEP)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
count  input  8  click count from the decoder, registered in the clk domain, wraps modulo 256
coarse  input  1  1 = use COARSE_STEP, 0 = use STEP; sampled per applied step
load  input  1  synchronous preset strobe
load_value  input  VALUE_W  preset value
value  output  VALUE_W  current tracked value
at_min  output  1  value == MIN_VAL
at_max  output  1  value == MAX_VAL
up_pulse  output  1  one-cycle pulse when an applied step increased value
down_pulse  output  1  one-cycle pulse when an applied step decreased value
busy  output  1  pending clicks not yet applied (pending != 0)

Behaviour:
- Reset (async, active-high) sets:
  - value = INIT_VAL; at_min/at_max consistent with INIT_VAL.
  - up_pulse = down_pulse = 0, busy = 0.
  - Internal: prev = 0, pending = 0, primed = 0.
- Priming: the first clock edge after reset release only captures prev <= count and sets primed = 1. No delta is generated, so a non-zero count at reset release causes no movement.
- Delta:
  - When primed, each edge computes delta = count - prev as an 8-bit two's-complement signed value (range -128..+127), then prev <= count.
  - Wrap-around is handled implicitly: 0xFE -> 0x02 gives +4; 0x01 -> 0xFF gives -2.
- Pending accumulator: 10-bit signed register.
  - Update per edge: pending_next = pending - sign(pending) + delta.
  - Saturates at +511 / -512; excess clicks are dropped.
- Step application: on each edge where pending != 0, apply one step of size S (S = COARSE_STEP if coarse, else STEP) in the direction of sign(pending).
  - Clicks entering pending at edge t produce their first value change at edge t+1. N clicks complete in N edges.
  - busy = (pending != 0), registered.
- Arithmetic: compute in VALUE_W+2 bits, unsigned/signed safe, with no intermediate overflow.
- Saturate mode (WRAP = 0):
  - Up: value = min(value+S, MAX_VAL). Down: value = max(value-S, MIN_VAL).
  - A click at a bound is consumed (pending still moves toward 0), but value is unchanged and no pulse is emitted.
- Wrap mode (WRAP = 1), with R = MAX_VAL-MIN_VAL+1:
  - Up: if value+S > MAX_VAL then value+S-R.
  - Down: if value < MIN_VAL+S then value-S+R.
  - A pulse is emitted on every step.
- Pulses: up_pulse / down_pulse are registered and asserted for exactly the cycle after the value changed; they are never both high.
- at_min / at_max are registered alongside value.
- Load (highest priority over step application):
  - value <= load_value clamped to [MIN_VAL, MAX_VAL].
  - pending <= 0; the delta on the same edge is discarded.
  - prev <= count; primed <= 1.
  - No pulse is emitted.
- Reset mid-operation discards pending clicks immediately and restarts from priming.

Test Plan:
- Reset release with count held at 0x37, then hold for 10 cycles -> value = 50, no pulses, busy = 0 throughout.
- After priming, count 0x00 -> 0x01 -> value 51 one edge later, up_pulse high for 1 cycle, busy high for 1 cycle.
- count 0xFE -> 0x02 in one cycle (STEP = 1) -> four consecutive up_pulses, value 50 -> 54, busy high for 4 cycles; repeat with coarse = 1 -> value 54 -> 94.
- Saturate: load 98, then +5 clicks -> value 99, 100, held at 100; exactly 2 up_pulses; at_max = 1; busy drops after 5 cycles. Mirror test at MIN_VAL with -5 clicks.
- WRAP = 1, MIN_VAL = 0, MAX_VAL = 9, STEP = 1:
  - value 9 plus 1 click -> 0 with up_pulse.
  - value 0 minus 1 click -> 9 with down_pulse.
  - COARSE_STEP = 4 from 7 up -> 1.
- Inject +20 clicks, then assert load = 1 with load_value = 200 after 3 steps -> value = 100, busy = 0 on the next cycle, no further pulses. Reset asserted mid-burst -> value = 50 immediately (async), with no pulses after release.
